// File: rtl/popcount_sequencer_if.sv
// Handshake and data bundle for popcount_sequencer.
// Optional threshold compare (Threshold in, Hit out) is compiled in by POPCOUNT_THRESH_EN.
interface popcount_sequencer_if #(
  parameter int unsigned N = 1024
);
  localparam int unsigned CW = $clog2(N) + 1;

  logic          Start;
  logic          Abort;
  logic [N-1:0]  Data;
  logic          Ready;
  logic          Busy;
  logic          Done;
  logic [CW-1:0] Count;
`ifdef POPCOUNT_THRESH_EN
  logic [CW-1:0] Threshold;
  logic          Hit;
`endif

  // Requester side: drives the frame and control, observes status and result.
  modport master (
    output Start,
    output Abort,
    output Data,
`ifdef POPCOUNT_THRESH_EN
    output Threshold,
    input  Hit,
`endif
    input  Ready,
    input  Busy,
    input  Done,
    input  Count
  );

  // Sequencer side.
  modport slave (
    input  Start,
    input  Abort,
    input  Data,
`ifdef POPCOUNT_THRESH_EN
    input  Threshold,
    output Hit,
`endif
    output Ready,
    output Busy,
    output Done,
    output Count
  );
endinterface

// File: rtl/popcount_sequencer.sv
// Multi-cycle population count of an N = SAMPLES*OSF bit frame, CHUNK bits per cycle.
// Frame is captured on an accepted Start, counted over NCH = N/CHUNK cycles and the result
// is published on Count together with a one-cycle Done pulse.
// Optional feature macro: POPCOUNT_THRESH_EN adds Threshold/Hit (Hit = ones >= Threshold).
module popcount_sequencer #(
  parameter int unsigned SAMPLES = 128,
  parameter int unsigned OSF     = 8,
  parameter int unsigned CHUNK   = 64
) (
  input logic                CLK,
  input logic                RST_N,
  popcount_sequencer_if.slave bus
);
  localparam int unsigned N   = SAMPLES * OSF;
  localparam int unsigned NCH = N / CHUNK;
  localparam int unsigned CW  = $clog2(N) + 1;
  localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned PW  = $clog2(CHUNK) + 1;

  if ((N % CHUNK) != 0) begin : g_bad_chunk
    $error("popcount_sequencer: N must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StLoad, StAcc, StDone} state_e;

  state_e        r_state;
  logic [N-1:0]  r_frame;
  logic [CW-1:0] r_acc;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_count;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;
`ifdef POPCOUNT_THRESH_EN
  logic [CW-1:0] r_thresh;
  logic          r_hit;
`endif

  logic [CHUNK-1:0] w_chunk;
  logic [PW-1:0]    w_chunk_ones;
  logic [CW-1:0]    w_acc_next;
  logic             w_last;

  assign w_chunk = r_frame[r_idx*CHUNK +: CHUNK];
  assign w_last  = (r_idx == IW'(NCH - 1));

  // Ones in the current chunk and the running total including it.
  always_comb begin
    w_chunk_ones = '0;
    for (int i = 0; i < CHUNK; i++) begin
      w_chunk_ones = w_chunk_ones + PW'(w_chunk[i]);
    end
    w_acc_next = r_acc + CW'(w_chunk_ones);
  end

  // Sequencer FSM with registered status outputs. Count/Done (and Hit) are loaded on the
  // edge that enters DONE so Count already holds the new result while Done is high.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= StIdle;
      r_frame  <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef POPCOUNT_THRESH_EN
      r_thresh <= '0;
      r_hit    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          // Abort takes priority over a simultaneous Start.
          if (bus.Start && !bus.Abort) begin
            r_frame  <= bus.Data;
`ifdef POPCOUNT_THRESH_EN
            r_thresh <= bus.Threshold;
`endif
            r_acc    <= '0;
            r_idx    <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= StLoad;
          end
        end
        StLoad: begin
          // Register stage so the wide frame fans out to the chunk mux from a flop.
          if (bus.Abort) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_state <= StAcc;
          end
        end
        StAcc: begin
          if (bus.Abort) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_acc <= w_acc_next;
            r_idx <= r_idx + IW'(1);
            if (w_last) begin
              r_count <= w_acc_next;
`ifdef POPCOUNT_THRESH_EN
              r_hit   <= (w_acc_next >= r_thresh);
`endif
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= StDone;
            end
          end
        end
        StDone: begin
          // Abort is ignored here; the result has already been published.
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= StIdle;
        end
        default: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.Ready = r_ready;
  assign bus.Busy  = r_busy;
  assign bus.Done  = r_done;
  assign bus.Count = r_count;
`ifdef POPCOUNT_THRESH_EN
  assign bus.Hit   = r_hit;
`endif

endmodule

// File: tb/tb_popcount_sequencer.sv
// Self-checking bench for popcount_sequencer: a cycle-count model predicts the status
// outputs and result every cycle, and directed frames pin literal results and latency.
module tb_popcount_sequencer;
  localparam int unsigned N   = 1024;
  localparam int unsigned NCH = 16;
  localparam int unsigned CW  = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  popcount_sequencer_if #(.N(N)) bus ();

  popcount_sequencer dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: m_cnt = cycles since the accepting edge (0 = idle, NCH+2 = done cycle).
  int            m_cnt = 0;
  logic [CW-1:0] m_pending = '0;
  logic [CW-1:0] m_count = '0;
  logic          m_hit = 1'b0;
  logic          m_hit_pending = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   <= 0;
      m_count <= '0;
      m_hit   <= 1'b0;
    end else if (m_cnt == 0) begin
      if (bus.Start && !bus.Abort) begin
        m_pending <= CW'($countones(bus.Data));
`ifdef POPCOUNT_THRESH_EN
        m_hit_pending <= ($countones(bus.Data) >= int'(bus.Threshold));
`endif
        m_cnt <= 1;
      end
    end else if (m_cnt <= NCH + 1) begin
      if (bus.Abort) begin
        m_cnt <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
        if (m_cnt == NCH + 1) begin
          m_count <= m_pending;
          m_hit   <= m_hit_pending;
        end
      end
    end else begin
      m_cnt <= 0;
    end
  end

  int done_seen = 0;
  int busy_seen = 0;

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready", 32'(bus.Ready), 32'(m_cnt == 0));
      check("busy", 32'(bus.Busy), 32'(m_cnt >= 1 && m_cnt <= NCH + 1));
      check("done", 32'(bus.Done), 32'(m_cnt == NCH + 2));
      check("count", 32'(bus.Count), 32'(m_count));
`ifdef POPCOUNT_THRESH_EN
      check("hit", 32'(bus.Hit), 32'(m_hit));
`endif
      if (bus.Done) done_seen++;
      if (bus.Busy) busy_seen++;
    end
  end

  // Start a frame from a negedge; returns at the negedge where Done is seen.
  task automatic run_frame(input logic [N-1:0] d, output int lat);
    bus.Data  = d;
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    lat = 1;
    while (!bus.Done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.Done) check("done_timeout", 32'(0), 32'(1));
  endtask

  function automatic logic [N-1:0] ones_frame(input int k);
    logic [N-1:0] f;
    f = '0;
    for (int i = 0; i < k; i++) f[i] = 1'b1;
    return f;
  endfunction

  int lat;
  int d0;
  logic [N-1:0] f;

  initial begin
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    bus.Data  = '0;
`ifdef POPCOUNT_THRESH_EN
    bus.Threshold = '0;
`endif
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.Ready), 32'(1));
    check("rst_busy", 32'(bus.Busy), 32'(0));
    check("rst_done", 32'(bus.Done), 32'(0));
    check("rst_count", 32'(bus.Count), 32'(0));
    rst_n = 1'b1;

    // All zeros: latency 18, busy 17 cycles.
    busy_seen = 0;
    run_frame('0, lat);
    check("zeros_latency", 32'(lat), 32'(18));
    check("zeros_count", 32'(bus.Count), 32'(0));
    check("zeros_busy_cycles", 32'(busy_seen), 32'(17));
    @(negedge clk);

    // All ones, then top bit only, then bottom bit only, each started right after Done.
    run_frame('1, lat);
    check("ones_count", 32'(bus.Count), 32'(1024));
    @(negedge clk);
    f = '0; f[N-1] = 1'b1;
    run_frame(f, lat);
    check("msb_count", 32'(bus.Count), 32'(1));
    @(negedge clk);
    f = '0; f[0] = 1'b1;
    run_frame(f, lat);
    check("lsb_count", 32'(bus.Count), 32'(1));
    check("lsb_latency", 32'(lat), 32'(18));
    @(negedge clk);

    // Alternating pattern; Data cleared and Start re-pulsed while counting.
    d0 = done_seen;
    for (int i = 0; i < N; i++) f[i] = i[0];
    bus.Data  = f;
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    bus.Data  = '0;
    repeat (5) @(negedge clk);
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (16) @(negedge clk);
    check("alt_count", 32'(bus.Count), 32'(512));
    check("alt_one_done", 32'(done_seen - d0), 32'(1));
    @(negedge clk);

    // 300 ones, then a frame aborted at chunk index 5.
    run_frame(ones_frame(300), lat);
    check("c300_count", 32'(bus.Count), 32'(300));
    @(negedge clk);
    d0 = done_seen;
    bus.Data  = '1;
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (6) @(negedge clk);
    bus.Abort = 1'b1;
    @(negedge clk);
    bus.Abort = 1'b0;
    check("abort_ready", 32'(bus.Ready), 32'(1));
    repeat (20) @(negedge clk);
    check("abort_no_done", 32'(done_seen - d0), 32'(0));
    check("abort_count_kept", 32'(bus.Count), 32'(300));

    // Abort in IDLE blocks a simultaneous Start.
    bus.Start = 1'b1;
    bus.Abort = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    check("idle_abort_blocks", 32'(bus.Ready), 32'(1));

    // Reset at chunk index 10, then a full frame.
    d0 = done_seen;
    bus.Data  = ones_frame(700);
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_ready", 32'(bus.Ready), 32'(1));
    check("rstmid_count", 32'(bus.Count), 32'(0));
    check("rstmid_busy", 32'(bus.Busy), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rstmid_no_done", 32'(done_seen - d0), 32'(0));
    run_frame('1, lat);
    check("post_rst_count", 32'(bus.Count), 32'(1024));
    @(negedge clk);

`ifdef POPCOUNT_THRESH_EN
    bus.Threshold = CW'(512);
    run_frame(ones_frame(511), lat);
    check("thr511_hit", 32'(bus.Hit), 32'(0));
    @(negedge clk);
    run_frame(ones_frame(512), lat);
    check("thr512_hit", 32'(bus.Hit), 32'(1));
    @(negedge clk);
    run_frame('1, lat);
    check("thr1024_hit", 32'(bus.Hit), 32'(1));
    @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
